branch_target_buffer: RTL

Direct-mapped branch target buffer with 2-bit saturating direction predictors. It sits between fetch and execute. Fetch looks up the current PC combinationally to get `predicted_taken` / `predicted_pc`. Execute writes back resolved branch and jump outcomes (`update_btb`, `calc_jump_addr`, actual direction) to train the table. It is the producer of the `predictedTaken` flag that execute consumes, and the consumer of execute's `update_btb` / `calc_jump_addr`.

---
 rtl/branch_target_buffer_if.sv | 26 ++
 rtl/branch_target_buffer.sv | 103 ++++++++++
 2 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-facing bus of the branch target buffer: the lookup path,
// the training write-back from execute, the flush and the perf counter.
interface branch_target_buffer_if #(
    parameter int CNT_W = 16
) ();
    logic [31:0]      if_pc;
    logic             predicted_taken;
    logic [31:0]      predicted_pc;
    logic             ex_update_en;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic             ex_taken;
    logic             ex_mispredict;
    logic             btb_flush;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output if_pc, ex_update_en, ex_pc, ex_target, ex_taken, ex_mispredict, btb_flush,
        input  predicted_taken, predicted_pc, mispredict_cnt
    );

    modport slave (
        input  if_pc, ex_update_en, ex_pc, ex_target, ex_taken, ex_mispredict, btb_flush,
        output predicted_taken, predicted_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with a 2-bit direction predictor per entry; combinational
// lookup for fetch, one training write per cycle from execute.
//
// state              | meaning
// STRONG_NOT_TAKEN 00| predict not taken, two taken outcomes to flip
// WEAK_NOT_TAKEN   01| predict not taken, next taken flips it
// STRONG_TAKEN     10| predict taken, two not-taken outcomes to flip
// WEAK_TAKEN       11| predict taken, next not-taken flips it (allocation state)
module branch_target_buffer #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_target_buffer_if.slave bus
);
    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        STRONG_NOT_TAKEN = 2'b00,
        WEAK_NOT_TAKEN   = 2'b01,
        STRONG_TAKEN     = 2'b10,
        WEAK_TAKEN       = 2'b11
    } pred_state_e;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    pred_state_e      state_q  [ENTRIES];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    logic                  if_hit, ex_hit, entry_we;
    logic [31:0]           entry_target_d;
    pred_state_e           entry_state_d, trained_state;
    logic                  unused_pc_bits;

    assign if_idx = bus.if_pc[INDEX_BITS+1:2];
    assign if_tag = bus.if_pc[31:INDEX_BITS+2];
    assign ex_idx = bus.ex_pc[INDEX_BITS+1:2];
    assign ex_tag = bus.ex_pc[31:INDEX_BITS+2];
    assign unused_pc_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

    always_comb begin
        if_hit              = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        bus.predicted_taken = if_hit && state_q[if_idx][1];
        bus.predicted_pc    = bus.predicted_taken ? target_q[if_idx] : bus.if_pc + 32'd4;
        bus.mispredict_cnt  = cnt_q;
    end

    always_comb begin
        ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        trained_state = state_q[ex_idx];
        if (bus.ex_taken) begin
            case (state_q[ex_idx])
                STRONG_NOT_TAKEN: trained_state = WEAK_NOT_TAKEN;
                WEAK_NOT_TAKEN:   trained_state = WEAK_TAKEN;
                WEAK_TAKEN:       trained_state = STRONG_TAKEN;
                default:          trained_state = STRONG_TAKEN;
            endcase
        end else begin
            case (state_q[ex_idx])
                STRONG_TAKEN:   trained_state = WEAK_TAKEN;
                WEAK_TAKEN:     trained_state = WEAK_NOT_TAKEN;
                WEAK_NOT_TAKEN: trained_state = STRONG_NOT_TAKEN;
                default:        trained_state = STRONG_NOT_TAKEN;
            endcase
        end

        // A not-taken miss leaves the table alone; a taken miss evicts the occupant.
        entry_we       = bus.ex_update_en && !bus.btb_flush && (ex_hit || bus.ex_taken);
        entry_state_d  = ex_hit ? trained_state : WEAK_TAKEN;
        entry_target_d = bus.ex_taken ? bus.ex_target : target_q[ex_idx];

        cnt_d = cnt_q;
        if (bus.ex_update_en && bus.ex_mispredict && !bus.btb_flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                state_q[i]  <= STRONG_NOT_TAKEN;
            end
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (bus.btb_flush) begin
                for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
            end else if (entry_we) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= entry_target_d;
                state_q[ex_idx]  <= entry_state_d;
            end
        end
    end
endmodule
